// File: rtl/riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_dmem_responder
//
// Data-memory model for the 5-stage core test harness. It accepts load/store
// requests, performs word/halfword/byte accesses against an internal word
// array, and returns one response per request after LAT cycles. Responses are
// buffered in a small output FIFO so the core can stall the response side.
//
// Handshake semantics (both channels): a transfer happens at a posedge where
// val && rdy are both high. A producer holds val and its message stable until
// that edge. memreq_rdy depends only on registered state and reset, never on
// memreq_val or memresp_rdy. memresp_msg_* are stable while memresp_val is
// high and memresp_rdy is low.
//
// Parameters:
//   ADDR_BITS  word-address width (array holds 2^ADDR_BITS 32-bit words)
//   LAT        acceptance-to-first-memresp_val latency, 1..4
//   OUT_DEPTH  maximum outstanding responses (pipeline plus output FIFO)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   memreq_val / memreq_rdy    request handshake
//   memreq_msg_type            0 = read, 1 = write
//   memreq_msg_addr            byte address (upper bits wrap)
//   memreq_msg_len             0/3 = word, 1 = byte, 2 = halfword
//   memreq_msg_data            right-aligned write data
//   memresp_val / memresp_rdy  response handshake
//   memresp_msg_type/len       echoed from the request
//   memresp_msg_data           right-aligned read data, 0 for writes
//   mem_init_en/addr/data      backdoor word write used for preloading
// -----------------------------------------------------------------------------
module riscv_dmem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LAT       = 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 memreq_val,
  output logic                 memreq_rdy,
  input  logic                 memreq_msg_type,
  input  logic [31:0]          memreq_msg_addr,
  input  logic [1:0]           memreq_msg_len,
  input  logic [31:0]          memreq_msg_data,

  output logic                 memresp_val,
  input  logic                 memresp_rdy,
  output logic                 memresp_msg_type,
  output logic [1:0]           memresp_msg_len,
  output logic [31:0]          memresp_msg_data,

  input  logic                 mem_init_en,
  input  logic [ADDR_BITS-1:0] mem_init_addr,
  input  logic [31:0]          mem_init_data
);

  // Response message layout: {type, len, data}
  localparam int MSG_W = 35;
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0] LEN_BYTE = 2'd1;
  localparam logic [1:0] LEN_HALF = 2'd2;

  // ---------------------------------------------------------------------------
  // Storage and request decode
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  logic [ADDR_BITS-1:0] req_idx;
  logic [1:0]           req_off;
  logic                 unused_addr_hi;

  logic                 req_fire;
  logic                 resp_fire;
  logic                 wr_fire;
  logic                 init_hit;

  logic [31:0]          rd_word;
  logic [31:0]          rd_data;
  logic [31:0]          wr_mask;
  logic [31:0]          wr_data;
  logic [31:0]          wr_base;
  logic [31:0]          wr_word;
  logic [MSG_W-1:0]     resp_in;

  assign req_idx = memreq_msg_addr[ADDR_BITS+1:2];
  assign req_off = memreq_msg_addr[1:0];

  // Address bits above the array are deliberately ignored (addresses wrap).
  assign unused_addr_hi = ^memreq_msg_addr[31:ADDR_BITS+2];

  assign req_fire  = memreq_val && memreq_rdy;
  assign resp_fire = memresp_val && memresp_rdy;
  assign wr_fire   = req_fire && memreq_msg_type;

  // The array is read combinationally so the value sampled at the acceptance
  // edge reflects every write committed at earlier edges.
  assign rd_word = mem[req_idx];

  // Subword read extraction, zero-extended and right-aligned.
  always_comb begin
    rd_data = rd_word;
    case (memreq_msg_len)
      LEN_BYTE: begin
        case (req_off)
          2'd0:    rd_data = {24'd0, rd_word[7:0]};
          2'd1:    rd_data = {24'd0, rd_word[15:8]};
          2'd2:    rd_data = {24'd0, rd_word[23:16]};
          default: rd_data = {24'd0, rd_word[31:24]};
        endcase
      end
      LEN_HALF: begin
        // addr[0] is ignored for halfwords
        rd_data = req_off[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
      end
      default: rd_data = rd_word;
    endcase
  end

  // Byte-lane mask and replicated write data for the addressed lanes.
  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_data = memreq_msg_data;
    case (memreq_msg_len)
      LEN_BYTE: begin
        wr_mask = 32'h0000_00FF << {req_off, 3'b000};
        wr_data = {4{memreq_msg_data[7:0]}};
      end
      LEN_HALF: begin
        wr_mask = req_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_data = {2{memreq_msg_data[15:0]}};
      end
      default: begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = memreq_msg_data;
      end
    endcase
  end

  // When the backdoor hits the same word in the same cycle, the untouched
  // bytes come from the init data rather than the old array contents, so the
  // request's bytes win and the rest take the init value.
  assign init_hit = mem_init_en && (mem_init_addr == req_idx);
  assign wr_base  = init_hit ? mem_init_data : rd_word;
  assign wr_word  = (wr_base & ~wr_mask) | (wr_data & wr_mask);

  // Array contents are intentionally not reset. The request write is issued
  // after the init write so it takes precedence on a shared word.
  always_ff @(posedge clk) begin
    if (mem_init_en) begin
      mem[mem_init_addr] <= mem_init_data;
    end
    if (wr_fire) begin
      mem[req_idx] <= wr_word;
    end
  end

  assign resp_in = {memreq_msg_type, memreq_msg_len,
                    memreq_msg_type ? 32'd0 : rd_data};

  // ---------------------------------------------------------------------------
  // Latency pipeline. The FIFO storage itself is the final register, so only
  // LAT-1 stages sit in front of it; with LAT = 1 a response enters the FIFO
  // directly at the acceptance edge.
  // ---------------------------------------------------------------------------
  logic             fifo_in_val;
  logic [MSG_W-1:0] fifo_in_msg;

  generate
    if (LAT == 1) begin : g_no_pipe
      assign fifo_in_val = req_fire;
      assign fifo_in_msg = resp_in;
    end else begin : g_pipe
      logic [LAT-1:1]   pipe_val;
      logic [MSG_W-1:0] pipe_msg [1:LAT-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          pipe_val <= '0;
        end else begin
          pipe_val[1] <= req_fire;
          for (int k = 2; k < LAT; k++) begin
            pipe_val[k] <= pipe_val[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        pipe_msg[1] <= resp_in;
        for (int k = 2; k < LAT; k++) begin
          pipe_msg[k] <= pipe_msg[k-1];
        end
      end

      assign fifo_in_val = pipe_val[LAT-1];
      assign fifo_in_msg = pipe_msg[LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [MSG_W-1:0] fifo_mem [0:OUT_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [MSG_W-1:0] fifo_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_in_val) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (resp_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({fifo_in_val, resp_fire})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_in_val && !reset) begin
      fifo_mem[wr_ptr] <= fifo_in_msg;
    end
  end

  assign fifo_head = fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Credit counter: responses accepted but not yet dequeued. Because
  // acceptance stops at OUT_DEPTH, the FIFO always has room for whatever the
  // pipeline delivers.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] credit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign memreq_rdy  = (credit_cnt < CNT_W'(OUT_DEPTH)) && !reset;
  assign memresp_val = (fifo_cnt != '0);

  // Stale FIFO slots are masked so an idle port shows an all-zero message.
  assign memresp_msg_type = memresp_val ? fifo_head[34]    : 1'b0;
  assign memresp_msg_len  = memresp_val ? fifo_head[33:32] : 2'd0;
  assign memresp_msg_data = memresp_val ? fifo_head[31:0]  : 32'd0;

  // ---------------------------------------------------------------------------
  // Internal invariants
  // ---------------------------------------------------------------------------
  a_credit_range: assert property (@(posedge clk) disable iff (reset)
    credit_cnt <= CNT_W'(OUT_DEPTH));

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_in_val && !resp_fire && (fifo_cnt == CNT_W'(OUT_DEPTH))));

endmodule

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder for the 5-stage core's data port: it accepts load/store requests over a val/rdy request channel, performs the word or subword access against an internal word array, and returns responses over a val/rdy response channel after a fixed, parameterised latency. Outstanding responses are buffered so the core's response side can apply backpressure. It sits in the core test harness, with the core's dmem request/response ports on one side and a backdoor init port used by the harness to preload program data.

## Interface
- ADDR_BITS, 12: word-address width; the array holds 2^ADDR_BITS 32-bit words.
- LAT, 1: cycles from request acceptance to earliest memresp_val; legal range 1..4.
- OUT_DEPTH, 2: maximum outstanding responses, counting pipeline plus output buffer; legal range ≥1. Full throughput requires OUT_DEPTH ≥ LAT+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- memreq_val  in  1  request valid
- memreq_rdy  out  1  request ready
- memreq_msg_type  in  1  request type: 0 = read, 1 = write
- memreq_msg_addr  in  32  byte address
- memreq_msg_len  in  2  access size: 0 = word, 1 = byte, 2 = halfword, 3 = word
- memreq_msg_data  in  32  write data, right-aligned
- memresp_val  out  1  response valid
- memresp_rdy  in  1  response ready
- memresp_msg_type  out  1  echoed request type
- memresp_msg_len  out  2  echoed request length
- memresp_msg_data  out  32  read data, right-aligned; 0 for writes
- mem_init_en  in  1  backdoor word write enable
- mem_init_addr  in  ADDR_BITS  backdoor word index
- mem_init_data  in  32  backdoor word data

## Operation
- **Acceptance.** A request is accepted at a posedge where memreq_val && memreq_rdy.
- **Word index.** The index is memreq_msg_addr[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- **Byte offset.** Byte access uses addr[1:0]. Halfword access uses addr[1], and addr[0] is ignored. Word access (len 0 or 3) ignores addr[1:0].
- **Read.**
  - The addressed bytes are read at the acceptance edge.
  - Byte reads are zero-extended into data[7:0]; halfword reads are zero-extended into data[15:0].
  - The result reflects every write accepted at earlier edges.
- **Write.**
  - The write is committed to the array at the acceptance edge.
  - Only the addressed bytes change: byte writes use data[7:0], halfword writes use data[15:0].
  - The response carries data = 0.
- **Response path.** Each accepted request produces exactly one response. Responses leave in acceptance order. They pass through a LAT-stage delay pipeline into an output FIFO of OUT_DEPTH entries.
- **Credit counter.** A counter tracks outstanding responses (accepted but not yet dequeued).
  - +1 on acceptance, −1 on memresp_val && memresp_rdy; unchanged when both happen on the same edge.
  - Range 0..OUT_DEPTH; it never overflows.
- **memreq_rdy.** Equals (count < OUT_DEPTH) && !reset.
  - It depends only on registered state: no combinational path from memreq_val or memresp_rdy.
  - Consequently the FIFO can always absorb pipeline output and no response is ever dropped.
- **memresp_val.** Equals FIFO non-empty. The memresp_msg_* fields equal the FIFO head and are held stable while val && !rdy.
- **Backdoor init.** When mem_init_en is high, mem_init_data is written to mem_init_addr at the edge.
  - If a request write is accepted at the same edge to the same word, the request's bytes win; the other bytes take the init data.
  - Init writes produce no response.
- **Reset.**
  - Flushes the pipeline and FIFO and clears the counter.
  - Array contents are not reset; writes committed before reset persist.

## Timing
- **Reset values.** memreq_rdy = 0 while reset is high, and 1 in the first cycle after reset falls. memresp_val = 0. memresp_msg_* = 0.
- **Latency.** A request accepted at edge N, with an empty FIFO ahead of it, shows memresp_val = 1 in the cycle following edge N+LAT−1. For LAT = 1 this is the cycle immediately after acceptance.
- **FIFO bypass.** Entering and leaving the FIFO adds no cycle when it is empty; the bypass is registered at the FIFO output.
- **Throughput.** One request and one response per cycle when OUT_DEPTH ≥ LAT+1 and memresp_rdy is held high.
- **Full.** With count == OUT_DEPTH, memreq_rdy is 0 for that whole cycle, even if memresp_rdy = 1. It returns to 1 the cycle after a dequeue.
- **Reset mid-operation.** All in-flight responses are discarded. No memresp_val occurs in the cycle after reset deasserts.

## Test plan
- **Word write then read.** Preload nothing. Write 0xDEADBEEF to 0x00000100 (len 0), then read 0x100 on the next cycle → the read response carries data 0xDEADBEEF, type 0, len 0, arriving LAT cycles after acceptance.
- **Subword.** After the word 0x11223344 is at 0x200:
  - Byte write 0xAA to 0x201, then word read of 0x200 → 0x1122AA44.
  - Halfword read of 0x202 → 0x00001122.
  - Byte read of 0x203 → 0x00000011.
- **Backpressure.** LAT = 1, OUT_DEPTH = 2, memresp_rdy = 0. Issue 3 back-to-back reads → only 2 are accepted and memreq_rdy stays 0. Raise memresp_rdy → responses drain in order, and the third request is accepted the cycle after the first dequeue.
- **Throughput.** LAT = 2, OUT_DEPTH = 3, memresp_rdy = 1. Issue 8 consecutive reads of preloaded words 0..7 → memreq_rdy is never 0, 8 responses arrive in order, and the first response appears 2 cycles after the first acceptance.
- **Reset flush and wrap.**
  - Reset while 2 responses are outstanding → memresp_val = 0 after reset, and the written data survives.
  - Read of address 4·2^ADDR_BITS + 0x10 returns word 4's contents.
